onehot_encoder_stream: RTL and testbench
========================================

# onehot_encoder_stream

- Converts a captured 16-bit request vector back to binary indices, one index per output handshake, lowest bit first.
- Inverse direction of the team's 4-to-16 one-hot decoder: the decoder expands an index into a one-hot word; this block collapses a one-hot or multi-hot word into its set-bit indices.
- Sits between the request-vector producer and any index consumer, with valid/ready on both sides.

## Interface
Parameters:
- WIDTH, 16, request vector width; only 16 is supported.
- IDX_W, 4, index width; localparam, equal to $clog2(WIDTH).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  request vector valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  16  request vector; bit i set means index i is requested.
- out_valid  output  1  out_idx valid.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  4  binary index of the current set bit.
- out_last  output  1  current beat is the final index of this vector.
- out_zero  output  1  zero-vector marker; constant 0 unless ONEHOT_ENC_ZERO_FLAG_EN is defined.

## Operation
- FSM states: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid with nonzero in_vec:
    - out_idx <= lowest set bit of in_vec.
    - pending <= in_vec with that bit cleared.
    - out_last <= (pending next value == 0).
    - Go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1.
  - On out_ready, if out_last=0:
    - out_idx <= lowest set bit of pending.
    - Clear that bit in pending.
    - out_last <= (remaining == 0).
  - On out_ready with out_last=1: go to IDLE, out_valid <= 0.
- Zero vector without the macro: accepted in IDLE (consumes the handshake), no output beat, stays IDLE.
- out_idx, out_last and out_zero are registered. They hold stable while out_valid=1 and out_ready=0.
- Priority: lowest index first. Indices are strictly increasing within one vector.
- Reset (any state, including mid-vector):
  - state=IDLE, pending=0, out_idx=0, out_last=0, out_zero=0, out_valid=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - The partially emitted vector is discarded.
- in_vec is sampled only on the accepting edge. Later changes have no effect.

## Timing
- Input accepted at edge N → out_valid=1 from cycle N+1.
- A vector with K set bits (K ≥ 1) occupies exactly K output handshakes. With out_ready held high, out_valid stays asserted for K consecutive cycles.
- After the last handshake there is one IDLE cycle (in_ready=1) before the next vector can be accepted. Peak throughput is K+1 cycles per vector.
- in_ready depends only on state; there is no combinational path from out_ready to in_ready.
- No combinational path from in_* to out_*.

## Configuration
- Macro: ONEHOT_ENC_ZERO_FLAG_EN.
- Defined:
  - A zero vector accepted in IDLE produces exactly one beat: out_idx=0, out_last=1, out_zero=1.
  - The beat obeys the normal handshake.
  - out_zero=0 on every nonzero-vector beat.
- Undefined:
  - Zero vectors are silently dropped as described in Operation.
  - out_zero is tied to 0.

## Structure
- Shared package onehot_enc_pkg holds:
  - the FSM state enum (IDLE, EMIT);
  - constants ENC_WIDTH=16 and ENC_IDX_W=4.
- Sub-module prio_enc_16x4: combinational lowest-set-bit priority encoder.
  - Inputs: 16-bit vector.
  - Outputs: 4-bit index and an "any" flag.
  - One instance is shared between the IDLE-load path and the EMIT-advance path through a 16-bit mux on its input.

## Test plan
- in_vec=0x8421 accepted, out_ready=1 → indices 0, 5, 10, 15 on four consecutive cycles; out_last=1 only on 15; in_ready returns one cycle after the last handshake.
- in_vec=0x0030, out_ready low for 3 cycles after out_valid rises → out_idx=4 held stable 3 cycles; then 5 with out_last=1.
- in_vec=0xFFFF → 16 beats, indices 0..15 in order, out_last on 15 only. Then in_vec=0x0001 → single beat, idx 0, out_last=1.
- in_vec=0x0000:
  - Macro undefined → no out_valid, in_ready stays 1.
  - Macro defined → one beat, idx 0, out_last=1, out_zero=1.
- rst pulsed after the second beat of 0x00F0 → next cycle out_valid=0, in_ready=1, out_idx=0. A following vector 0x0100 emits only idx 8.
- in_valid held high across a whole vector with in_vec changing each cycle → only the vector present at the accepting edge is emitted.

Source files
------------

// File: rtl/onehot_enc_pkg.sv
// ============================================================================
// Module      : onehot_enc_pkg
// Description : Shared types and constants for the one-hot/multi-hot index
//               encoder stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package onehot_enc_pkg;

    localparam int ENC_WIDTH = 16;
    localparam int ENC_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_e;

endpackage : onehot_enc_pkg

`default_nettype wire

// File: rtl/prio_enc_16x4.sv
// ============================================================================
// Module      : prio_enc_16x4
// Description : Combinational lowest-set-bit priority encoder, 16 to 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc_16x4
    import onehot_enc_pkg::*;
(
    input  logic [ENC_WIDTH-1:0] vec,
    output logic [ENC_IDX_W-1:0] idx,
    output logic                 any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = ENC_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ENC_IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule : prio_enc_16x4

`default_nettype wire

// File: rtl/onehot_encoder_stream.sv
// ============================================================================
// Module      : onehot_encoder_stream
// Description : Collapses a captured 16-bit request vector into a stream of
//               set-bit indices, lowest first, valid/ready on both sides.
//               Optional macro ONEHOT_ENC_ZERO_FLAG_EN emits a marker beat
//               for an all-zero vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_encoder_stream
    import onehot_enc_pkg::*;
#(
    parameter  int WIDTH = ENC_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
);

    enc_state_e       r_state;
    enc_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [IDX_W-1:0] r_idx;
    logic             r_last;
    logic [WIDTH-1:0] w_enc_in;
    logic [WIDTH-1:0] w_cleared;
    logic [IDX_W-1:0] w_enc_idx;
    logic             w_enc_any;
    logic             w_accept;
    logic             w_advance;

    // One encoder serves both the load path and the advance path.
    assign w_enc_in  = (r_state == IDLE) ? in_vec : r_pending;
    assign w_cleared = w_enc_in & (w_enc_in - WIDTH'(1));

    prio_enc_16x4 u_prio_enc (
        .vec (w_enc_in),
        .idx (w_enc_idx),
        .any (w_enc_any)
    );

    assign w_accept  = in_ready & in_valid;
    assign w_advance = out_valid & out_ready & ~r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
`ifdef ONEHOT_ENC_ZERO_FLAG_EN
                if (in_valid) begin
                    w_state_nxt = EMIT;
                end
`else
                if (in_valid && w_enc_any) begin
                    w_state_nxt = EMIT;
                end
`endif
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready && r_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef ONEHOT_ENC_ZERO_FLAG_EN
    logic r_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_idx     <= '0;
            r_last    <= 1'b0;
`ifdef ONEHOT_ENC_ZERO_FLAG_EN
            r_zero    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_pending <= w_cleared;
            r_idx     <= w_enc_idx;
            // An empty vector yields idx 0 and cleared==0, i.e. a lone last beat.
            r_last    <= (w_cleared == '0);
`ifdef ONEHOT_ENC_ZERO_FLAG_EN
            r_zero    <= ~w_enc_any;
`endif
        end else if (w_advance) begin
            r_pending <= w_cleared;
            r_idx     <= w_enc_idx;
            r_last    <= (w_cleared == '0);
        end
    end

    assign out_idx  = r_idx;
    assign out_last = r_last;
`ifdef ONEHOT_ENC_ZERO_FLAG_EN
    assign out_zero = r_zero;
`else
    assign out_zero = 1'b0;
`endif

endmodule : onehot_encoder_stream

`default_nettype wire

// File: tb/tb_onehot_encoder_stream.sv
// ============================================================================
// Module      : tb_onehot_encoder_stream
// Description : Directed self-checking bench for onehot_encoder_stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_encoder_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        out_zero;

    int checks;
    int failures;

    onehot_encoder_stream u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents vec for exactly one edge while the DUT is idle, then scrambles in_vec.
    task automatic send(input logic [15:0] vec);
        in_valid = 1'b1;
        in_vec   = vec;
        tick();
        in_valid = 1'b0;
        in_vec   = 16'hA5A5;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 16'h0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, out_idx, out_last, out_zero} !== 8'b0_1_0000_0_0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b",
                     {out_valid, in_ready, out_idx, out_last, out_zero}, 8'b0_1_0000_0_0);
        end
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_stream();
        logic [3:0] exp_idx [4];
        exp_idx = '{4'd0, 4'd5, 4'd10, 4'd15};
        out_ready = 1'b1;
        send(16'h8421);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, in_ready, out_idx, out_last, out_zero} !==
                {1'b1, 1'b0, exp_idx[i], (i == 3), 1'b0}) begin
                failures++;
                $display("FAIL stream_beat%0d got=%b exp=%b", i,
                         {out_valid, in_ready, out_idx, out_last, out_zero},
                         {1'b1, 1'b0, exp_idx[i], (i == 3), 1'b0});
            end
            tick();
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL stream_return_idle got=%b exp=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(16'h0030);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, out_idx, out_last} !== {1'b1, 4'd4, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b exp=%b", i,
                         {out_valid, out_idx, out_last}, {1'b1, 4'd4, 1'b0});
            end
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if ({out_valid, out_idx, out_last} !== {1'b1, 4'd4, 1'b0}) begin
            failures++;
            $display("FAIL bp_release got=%b exp=%b",
                     {out_valid, out_idx, out_last}, {1'b1, 4'd4, 1'b0});
        end
        tick();
        checks++;
        if ({out_valid, out_idx, out_last} !== {1'b1, 4'd5, 1'b1}) begin
            failures++;
            $display("FAIL bp_last got=%b exp=%b",
                     {out_valid, out_idx, out_last}, {1'b1, 4'd5, 1'b1});
        end
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_idle got=%b exp=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_full_then_single();
        out_ready = 1'b1;
        send(16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({out_valid, out_idx, out_last, out_zero} !==
                {1'b1, 4'(i), (i == 15), 1'b0}) begin
                failures++;
                $display("FAIL full_beat%0d got=%b exp=%b", i,
                         {out_valid, out_idx, out_last, out_zero},
                         {1'b1, 4'(i), (i == 15), 1'b0});
            end
            tick();
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL full_idle got=%b exp=01", {out_valid, in_ready});
        end
        send(16'h0001);
        checks++;
        if ({out_valid, out_idx, out_last, out_zero} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_beat got=%b exp=%b",
                     {out_valid, out_idx, out_last, out_zero}, {1'b1, 4'd0, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_done got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        send(16'h0000);
`ifdef ONEHOT_ENC_ZERO_FLAG_EN
        checks++;
        if ({out_valid, in_ready, out_idx, out_last, out_zero} !== 8'b1_0_0000_1_1) begin
            failures++;
            $display("FAIL zero_flag_beat got=%b exp=%b",
                     {out_valid, in_ready, out_idx, out_last, out_zero}, 8'b1_0_0000_1_1);
        end
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL zero_flag_done got=%b exp=01", {out_valid, in_ready});
        end
`else
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, in_ready, out_zero} !== 3'b010) begin
                failures++;
                $display("FAIL zero_drop%0d got=%b exp=010", i, {out_valid, in_ready, out_zero});
            end
            tick();
        end
`endif
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(16'h00F0);
        tick();
        tick();
        checks++;
        if ({out_valid, out_idx} !== {1'b1, 4'd6}) begin
            failures++;
            $display("FAIL mid_pre got=%b exp=%b", {out_valid, out_idx}, {1'b1, 4'd6});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, out_idx, out_last} !== {1'b0, 1'b1, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=%b",
                     {out_valid, in_ready, out_idx, out_last}, {1'b0, 1'b1, 4'd0, 1'b0});
        end
        send(16'h0100);
        checks++;
        if ({out_valid, out_idx, out_last} !== {1'b1, 4'd8, 1'b1}) begin
            failures++;
            $display("FAIL mid_next got=%b exp=%b",
                     {out_valid, out_idx, out_last}, {1'b1, 4'd8, 1'b1});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_next_done got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_input_hold();
        logic [15:0] noise [3];
        noise = '{16'hFFFF, 16'h8000, 16'h0000};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 16'h0003;
        tick();
        for (int i = 0; i < 2; i++) begin
            in_vec = noise[i];
            checks++;
            if ({out_valid, in_ready, out_idx, out_last} !== {1'b1, 1'b0, 4'(i), (i == 1)}) begin
                failures++;
                $display("FAIL hold_beat%0d got=%b exp=%b", i,
                         {out_valid, in_ready, out_idx, out_last}, {1'b1, 1'b0, 4'(i), (i == 1)});
            end
            tick();
        end
        in_vec = noise[2];
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL hold_idle got=%b exp=01", {out_valid, in_ready});
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_then_single();
        test_zero();
        test_reset_mid();
        test_input_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_onehot_encoder_stream

`default_nettype wire
